serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single-bit line, one framed bit per bit period. It is the driving end of the single-bit serial input (Din) used by the team's clocked bit-stream receivers and detectors. Its Dout connects directly to a receiver's Din on the same CLK.

Parameters:
DATA_W, 8, payload width in bits (>=2)
CLKS_PER_BIT, 1, CLK cycles per transmitted bit (>=1); 1 = one bit per clock, matching the receivers' sampling

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  payload word; sampled only at handshake
tx_valid  input  1  payload available
tx_ready  output  1  transmitter can accept a word
Dout  output  1  serial line; registered
busy  output  1  high while a frame is on the line
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; Dout=0, tx_ready=1, busy=0, done=0; shift register and counters cleared. Asserting reset mid-frame aborts the frame immediately and drops the word. No partial frame resumes after release.
- Line levels: idle=0, start bit=1, data MSB first, stop bit=0.
- Handshake: a word is accepted on a rising CLK edge with tx_valid=1 and tx_ready=1. tx_ready=1 only in IDLE. tx_data changes after acceptance are ignored.
- FSM states: IDLE -> START (on accept) -> DATA (DATA_W bits) -> [PARITY, only with the optional feature] -> STOP -> IDLE.
- Each non-IDLE state holds Dout for exactly CLKS_PER_BIT cycles, timed by a bit-tick divider.
- Latency: Dout=1 (start bit) in the first cycle after the accepting edge.
- Frame length: (DATA_W+2) bit periods, or DATA_W+3 with parity.
- busy=1 from the first start-bit cycle through the last stop-bit cycle.
- done=1 for exactly one cycle: the first cycle back in IDLE, with tx_ready=1 and busy=0.
- Back-to-back: if tx_valid stays high, the next word is accepted on the edge ending the done cycle. This gives exactly one idle-level (0) cycle between frames.
- Widths: bit counter is $clog2(DATA_W+1) bits. The divider counter is $clog2(CLKS_PER_BIT) bits; when CLKS_PER_BIT=1 the divider is bypassed (tick every cycle).
- The bit counter wraps to 0 only on the STOP->IDLE transition. Counter values outside the legal range force IDLE.
- tx_valid is ignored outside IDLE. Words are never dropped, only stalled.

Optional Feature:
- Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined: PARITY state between DATA and STOP; Dout = even parity (XOR of the payload), computed at acceptance.
- Undefined: no PARITY state; DATA goes directly to STOP. Port list is identical in both builds.

Decomposition:
- Package serial_frame_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=0, LINE_START=1, LINE_STOP=0.
- One sub-module, bit_tick_divider: parameter CLKS_PER_BIT; ports CLK, RST, clr, tick. Pulses tick every CLKS_PER_BIT cycles; clr restarts the count.

Test Plan (DATA_W=8, CLKS_PER_BIT=1 unless stated):
- Reset then idle, no tx_valid for 20 cycles -> Dout=0, tx_ready=1, busy=0, done never asserted.
- Send 8'hA5 -> Dout over the 10 cycles after accept = 1,1,0,1,0,0,1,0,1,0. busy high for those 10 cycles; done pulses in cycle 11.
- tx_valid held high with 8'hFF then 8'h00 -> frames 1,11111111,0 then a single idle 0 cycle, then 1,00000000,0. tx_ready low throughout each frame.
- CLKS_PER_BIT=4, send 8'h80 -> each bit held exactly 4 cycles; start bit cycles 1-4, MSB=1 cycles 5-8; frame totals 40 cycles.
- RST pulsed low during data bit 3 of 8'hC3 -> Dout=0 and tx_ready=1 asynchronously. After release, no residual bits; the next accepted 8'h3C transmits cleanly.
- With SERIAL_FRAME_TX_PARITY_EN: 8'hA5 -> parity bit 0, frame 11 bits. 8'hA4 -> parity bit 1 in bit period 10.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared FSM states and line levels for serial_frame_tx
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/bit_tick_divider.sv
// rtl/bit_tick_divider.sv - one-cycle tick every CLKS_PER_BIT clocks, restartable by clr
module bit_tick_divider #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    generate
        if (CLKS_PER_BIT == 1) begin : g_bypass
            // One bit per clock: nothing to count.
            logic unused_inputs;
            assign unused_inputs = &{1'b0, CLK, RST, clr};
            assign tick = 1'b1;
        end else begin : g_div
            localparam int CW = $clog2(CLKS_PER_BIT);
            localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

            logic [CW-1:0] cnt;

            assign tick = (cnt == LAST);

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    cnt <= '0;
                end else if (clr || tick) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed serial transmitter; parity bit when SERIAL_FRAME_TX_PARITY_EN is defined
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              Dout,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              tick;
    logic              accept;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              par_bit;
`endif

    assign accept = (state == IDLE) && tx_valid;

    bit_tick_divider #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_div (
        .CLK (CLK),
        .RST (RST),
        .clr (accept),
        .tick(tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            Dout     <= LINE_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state    <= START;
                        shreg    <= tx_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par_bit  <= ^tx_data;
`endif
                        Dout     <= LINE_START;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        Dout    <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                DATA: begin
                    // bit_cnt counts bits already put on the line; outside 1..DATA_W is corrupt.
                    if (bit_cnt == '0 || bit_cnt > LAST_BIT) begin
                        state    <= IDLE;
                        Dout     <= LINE_IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                    end else if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            state <= PARITY;
                            Dout  <= par_bit;
`else
                            state <= STOP;
                            Dout  <= LINE_STOP;
`endif
                        end else begin
                            Dout    <= shreg[DATA_W-1];
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        Dout  <= LINE_STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state    <= IDLE;
                        Dout     <= LINE_IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    Dout     <= LINE_IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench: one-clock-per-bit and four-clock-per-bit instances
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [7:0] data [2];
    logic [1:0] ready, dout, busy, done;

    int errors = 0;
    int checks = 0;

    int         pos [2] = '{-1, -1};
    logic [7:0] word [2];

    always #5 CLK = ~CLK;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .CLK(CLK), .RST(RST), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .Dout(dout[0]), .busy(busy[0]), .done(done[0])
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .CLK(CLK), .RST(RST), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .Dout(dout[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int cpb_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Bit k of the frame: start, payload MSB first, optional even parity, stop.
    function automatic logic frame_bit(logic [7:0] w, int k);
        if (k == 0) return 1'b1;
        if (k <= 8) return w[8-k];
`ifdef SERIAL_FRAME_TX_PARITY_EN
        if (k == 9) return ^w;
`endif
        return 1'b0;
    endfunction

    // {Dout, busy, tx_ready, done} for cycle p of a frame (p<0: idle).
    function automatic logic [3:0] expect_out(int p, logic [7:0] w, int cpb);
        if (p < 0 || p > NB * cpb) return 4'b0010;
        if (p == NB * cpb) return 4'b0011;
        return {frame_bit(w, p / cpb), 3'b100};
    endfunction

    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                pos[i] = -1;
            end else if ((pos[i] < 0 || pos[i] >= NB * cpb_of(i)) && valid[i]) begin
                pos[i]  = 0;
                word[i] = data[i];
            end else if (pos[i] >= 0) begin
                pos[i] = pos[i] + 1;
                if (pos[i] > NB * cpb_of(i)) pos[i] = -1;
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] e, g;
            e = expect_out(pos[i], word[i], cpb_of(i));
            g = {dout[i], busy[i], ready[i], done[i]};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_cmp inst=%0d t=%0t got{dout,busy,ready,done}=%b expected=%b",
                         i, $time, g, e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit keep);
        bit ok;
        @(negedge CLK);
        #1;
        data[i]  = d;
        valid[i] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge CLK);
            #1;
            if (pos[i] == 0) ok = 1'b1;
        end
        if (!keep) valid[i] = 1'b0;
        chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic capture(input int i, input int n, output logic [63:0] cap, output logic [63:0] bz);
        cap = '0;
        bz  = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            cap = {cap[62:0], dout[i]};
            bz  = {bz[62:0], busy[i]};
        end
    endtask

    task automatic check_done(input string name, input int i);
        @(negedge CLK);
        chk(name, {61'd0, done[i], ready[i], busy[i]}, 64'b110);
    endtask

    initial begin
        logic [63:0] cap, bz, rd;
        int done_cnt;

        data[0] = 8'h00;
        data[1] = 8'h00;
        repeat (3) @(negedge CLK);
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_ready", 64'(ready), 64'd3);
        #1 RST = 1'b1;

        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (done[0] || done[1]) done_cnt++;
        end
        chk("idle_no_done", 64'(done_cnt), 64'd0);

        send(0, 8'hA5, 1'b0);
        capture(0, NB, cap, bz);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("a5_bits", cap, 64'b11010010100);
`else
        chk("a5_bits", cap, 64'b1101001010);
`endif
        chk("a5_busy", bz, (64'd1 << NB) - 1);
        check_done("a5_done", 0);

`ifdef SERIAL_FRAME_TX_PARITY_EN
        send(0, 8'hA4, 1'b0);
        capture(0, NB, cap, bz);
        chk("a4_bits", cap, 64'b11010010010);
        check_done("a4_done", 0);
`endif

        send(0, 8'hFF, 1'b1);
        data[0] = 8'h00;
        cap = '0;
        rd  = '0;
        for (int k = 0; k < 2 * NB + 1; k++) begin
            @(negedge CLK);
            cap = {cap[62:0], dout[0]};
            rd  = {rd[62:0], ready[0]};
            if (k == NB + 1) valid[0] = 1'b0;
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("b2b_bits", cap, {41'd0, 11'b11111111100, 1'b0, 11'b10000000000});
`else
        chk("b2b_bits", cap, {42'd0, 10'b1111111110, 1'b0, 10'b1000000000});
`endif
        chk("b2b_ready", rd, 64'd1 << NB);
        check_done("b2b_done", 0);

        send(1, 8'h80, 1'b0);
        capture(1, NB * 4, cap, bz);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("cpb4_bits", cap, 64'hFF0000000F0);
`else
        chk("cpb4_bits", cap, 64'hFF00000000);
`endif
        chk("cpb4_busy", bz, (64'd1 << (NB * 4)) - 1);
        check_done("cpb4_done", 1);

        send(0, 8'hC3, 1'b0);
        repeat (4) @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("abort_async", {61'd0, dout[0], ready[0], busy[0]}, 64'b010);
        @(negedge CLK);
        #1 RST = 1'b1;
        repeat (5) @(negedge CLK);

        send(0, 8'h3C, 1'b0);
        capture(0, NB, cap, bz);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("after_abort_bits", cap, 64'b10011110000);
`else
        chk("after_abort_bits", cap, 64'b1001111000);
`endif
        check_done("after_abort_done", 0);

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
